// File: rtl/j1_io_fabric.sv
// J1 I/O fabric: decodes CPU I/O pages onto peripheral slots and a small block
// of control registers holding interrupt pending/mask state and decode-error tracking.
module j1_io_fabric #(
    parameter int unsigned N_SLOTS       = 8,
    parameter logic [7:0]  BASE_PAGE     = 8'h60,
    parameter logic [7:0]  CTRL_PAGE     = 8'h7F,
    parameter logic [15:0] DEFAULT_RDATA = 16'h0666
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic                  io_rd,
    input  logic                  io_wr,
    input  logic [15:0]           io_addr,
    input  logic [15:0]           io_dout,
    output logic [15:0]           io_din,
    output logic [N_SLOTS-1:0]    per_cs,
    output logic                  per_rd,
    output logic                  per_wr,
    output logic [7:0]            per_addr,
    output logic [15:0]           per_wdata,
    input  logic [16*N_SLOTS-1:0] per_rdata,
    input  logic [N_SLOTS-1:0]    per_irq,
    output logic                  irq
);

    localparam int unsigned DW = 16;
    localparam int unsigned IW = 4;
    localparam logic [8:0]  SLOT_END = 9'(BASE_PAGE) + 9'(N_SLOTS);
    localparam logic [15:0] ID_VALUE = {8'hF1, 8'(N_SLOTS)};

    localparam logic [3:0] REG_ID   = 4'h0;
    localparam logic [3:0] REG_PEND = 4'h1;
    localparam logic [3:0] REG_MASK = 4'h2;
    localparam logic [3:0] REG_EADR = 4'h3;
    localparam logic [3:0] REG_ECNT = 4'h4;

    logic [7:0]         page;
    logic               strobe;
    logic               ctrl_hit;
    logic               slot_hit;
    logic               unmapped;
    logic [IW-1:0]      slot_idx;
    logic [3:0]         reg_sel;
    logic               ctrl_wr;
    logic [DW-1:0]      slot_rdata;
    logic [DW-1:0]      ctrl_rdata;
    logic [DW-1:0]      rd_data;
    logic [N_SLOTS-1:0] w1c_mask;
    logic [N_SLOTS-1:0] irq_rise;

    logic [N_SLOTS-1:0] irq_sync;
    logic [N_SLOTS-1:0] irq_prev;
    logic [N_SLOTS-1:0] irq_pend;
    logic [N_SLOTS-1:0] irq_mask;
    logic [DW-1:0]      err_addr;
    logic [DW-1:0]      err_cnt;

    assign page      = io_addr[15:8];
    assign strobe    = io_rd | io_wr;
    assign reg_sel   = io_addr[3:0];
    assign ctrl_hit  = (page == CTRL_PAGE);
    // The control page shadows any slot that happens to share its page.
    assign slot_hit  = ({1'b0, page} >= {1'b0, BASE_PAGE}) && ({1'b0, page} < SLOT_END) && !ctrl_hit;
    assign slot_idx  = IW'(page - BASE_PAGE);
    assign unmapped  = strobe && !ctrl_hit && !slot_hit;
    assign ctrl_wr   = io_wr && ctrl_hit;

    assign per_rd    = io_rd;
    assign per_wr    = io_wr;
    assign per_addr  = io_addr[7:0];
    assign per_wdata = io_dout;

    always_comb begin
        per_cs     = '0;
        slot_rdata = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (slot_idx == IW'(i)) begin
                per_cs[i]  = strobe && slot_hit;
                slot_rdata = per_rdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        ctrl_rdata = '0;
        case (reg_sel)
            REG_ID:   ctrl_rdata = ID_VALUE;
            REG_PEND: ctrl_rdata = DW'(irq_pend);
            REG_MASK: ctrl_rdata = DW'(irq_mask);
            REG_EADR: ctrl_rdata = err_addr;
            REG_ECNT: ctrl_rdata = err_cnt;
            default:  ctrl_rdata = '0;
        endcase
    end

    always_comb begin
        rd_data = DEFAULT_RDATA;
        if (ctrl_hit) begin
            rd_data = ctrl_rdata;
        end else if (slot_hit) begin
            rd_data = slot_rdata;
        end
    end

    assign w1c_mask = (ctrl_wr && reg_sel == REG_PEND) ? io_dout[N_SLOTS-1:0] : '0;
    assign irq_rise = irq_sync & ~irq_prev;

    // Register file, interrupt edge capture and read-data return.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            irq_sync <= '0;
            irq_prev <= '0;
            irq_pend <= '0;
            irq_mask <= '0;
            err_addr <= '0;
            err_cnt  <= '0;
            irq      <= 1'b0;
            io_din   <= '0;
        end else begin
            irq_sync <= per_irq;
            irq_prev <= irq_sync;
            irq_pend <= (irq_pend & ~w1c_mask) | irq_rise;
            if (ctrl_wr && reg_sel == REG_MASK) begin
                irq_mask <= io_dout[N_SLOTS-1:0];
            end
            if (unmapped) begin
                err_addr <= io_addr;
            end
            if (ctrl_wr && reg_sel == REG_ECNT) begin
                err_cnt <= '0;
            end else if (unmapped && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
            irq <= |(irq_pend & irq_mask);
            if (io_rd) begin
                io_din <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_j1_io_fabric.sv
// Bench for j1_io_fabric: directed and randomized accesses checked against a
// cycle-level behavioural model of the register map and decode.
module tb_j1_io_fabric;

    localparam int unsigned NS = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           io_rd = 1'b0;
    logic           io_wr = 1'b0;
    logic [15:0]    io_addr = '0;
    logic [15:0]    io_dout = '0;
    logic [15:0]    io_din;
    logic [NS-1:0]  per_cs;
    logic           per_rd;
    logic           per_wr;
    logic [7:0]     per_addr;
    logic [15:0]    per_wdata;
    logic [16*NS-1:0] per_rdata = '0;
    logic [NS-1:0]  per_irq = '0;
    logic           irq;

    // Second instance: control page overlaps slot 2 (pages 7D,7E,7F,80).
    logic [15:0]    b_din;
    logic [3:0]     b_cs;
    logic           b_rd;
    logic           b_wr;
    logic [7:0]     b_addr;
    logic [15:0]    b_wdata;
    logic           b_irq;

    always #5 clk = ~clk;

    j1_io_fabric #(.N_SLOTS(NS)) dut (
        .sys_clk_i (clk),       .sys_rst_i (rst),
        .io_rd     (io_rd),     .io_wr     (io_wr),
        .io_addr   (io_addr),   .io_dout   (io_dout),
        .io_din    (io_din),    .per_cs    (per_cs),
        .per_rd    (per_rd),    .per_wr    (per_wr),
        .per_addr  (per_addr),  .per_wdata (per_wdata),
        .per_rdata (per_rdata), .per_irq   (per_irq),
        .irq       (irq)
    );

    j1_io_fabric #(.N_SLOTS(4), .BASE_PAGE(8'h7D)) dut_b (
        .sys_clk_i (clk),             .sys_rst_i (rst),
        .io_rd     (io_rd),           .io_wr     (io_wr),
        .io_addr   (io_addr),         .io_dout   (io_dout),
        .io_din    (b_din),           .per_cs    (b_cs),
        .per_rd    (b_rd),            .per_wr    (b_wr),
        .per_addr  (b_addr),          .per_wdata (b_wdata),
        .per_rdata (per_rdata[63:0]), .per_irq   (per_irq[3:0]),
        .irq       (b_irq)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0]   slot_data [NS];
    logic [NS-1:0] m_pend, m_mask, m_s1, m_s2;
    logic [15:0]   m_eaddr, m_ecnt, m_din;
    logic          m_irq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NS-1:0] exp_cs(input logic [15:0] addr, input logic stb);
        logic [7:0] pg;
        pg = addr[15:8];
        if (stb && pg >= 8'h60 && pg < 8'h60 + 8'(NS)) return NS'(1) << (pg - 8'h60);
        return '0;
    endfunction

    function automatic logic [3:0] exp_cs_b(input logic [15:0] addr, input logic stb);
        logic [7:0] pg;
        pg = addr[15:8];
        if (stb && pg >= 8'h7D && pg <= 8'h80 && pg != 8'h7F) return 4'(1) << (pg - 8'h7D);
        return '0;
    endfunction

    function automatic logic [15:0] reg_val(input logic [3:0] sel);
        case (sel)
            4'h0: return 16'hF10C;
            4'h1: return 16'(m_pend);
            4'h2: return 16'(m_mask);
            4'h3: return m_eaddr;
            4'h4: return m_ecnt;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_s1 = '0; m_s2 = '0;
        m_eaddr = '0; m_ecnt = '0; m_din = '0; m_irq = 1'b0;
    endtask

    task automatic cycle(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] dout, input logic [NS-1:0] irqv);
        logic [7:0]  pg;
        logic        is_ctrl, is_slot, is_unm, is_wctrl;
        logic [15:0] rv;
        logic        nxt_irq;
        io_rd = rd; io_wr = wr; io_addr = addr; io_dout = dout; per_irq = irqv;
        #1;
        chk("per_cs", 32'(per_cs), 32'(exp_cs(addr, rd | wr)));
        chk("per_cs_overlap", 32'(b_cs), 32'(exp_cs_b(addr, rd | wr)));
        chk("passthru", {6'd0, per_rd, per_wr, per_addr, per_wdata}, {6'd0, rd, wr, addr[7:0], dout});
        pg       = addr[15:8];
        is_ctrl  = (pg == 8'h7F);
        is_slot  = (pg >= 8'h60 && pg < 8'h60 + 8'(NS));
        is_unm   = (rd | wr) && !is_ctrl && !is_slot;
        is_wctrl = wr && is_ctrl;
        rv       = is_ctrl ? reg_val(addr[3:0]) : is_slot ? slot_data[pg - 8'h60] : 16'h0666;
        nxt_irq  = |(m_pend & m_mask);
        if (is_wctrl && addr[3:0] == 4'h1) m_pend = m_pend & ~dout[NS-1:0];
        m_pend = m_pend | (m_s1 & ~m_s2);
        if (is_wctrl && addr[3:0] == 4'h2) m_mask = dout[NS-1:0];
        if (is_unm) m_eaddr = addr;
        if (is_wctrl && addr[3:0] == 4'h4) m_ecnt = 16'h0;
        else if (is_unm && m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
        m_s2 = m_s1;
        m_s1 = irqv;
        if (rd) m_din = rv;
        m_irq = nxt_irq;
        @(posedge clk);
        #1;
        chk("io_din", 32'(io_din), 32'(m_din));
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic reset_cycle(input logic rd, input logic wr, input logic [15:0] addr);
        rst = 1'b1; io_rd = rd; io_wr = wr; io_addr = addr; io_dout = 16'hFFFF; per_irq = '0;
        #1;
        chk("rst_per_cs", 32'(per_cs), 32'(exp_cs(addr, rd | wr)));
        chk("rst_passthru", {7'd0, per_rd, per_wr, per_addr}, {7'd0, rd, wr, addr[7:0]});
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_io_din", 32'(io_din), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
    endtask

    task automatic idle(input logic [NS-1:0] irqv);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, irqv);
    endtask

    initial begin
        logic [1:0]  rw;
        logic [15:0] a;
        for (int i = 0; i < int'(NS); i++) begin
            slot_data[i] = 16'($urandom);
        end
        slot_data[3] = 16'hBEEF;
        for (int i = 0; i < int'(NS); i++) begin
            per_rdata[i*16 +: 16] = slot_data[i];
        end
        model_reset();
        @(posedge clk);
        #1;
        reset_cycle(1'b0, 1'b0, 16'h0000);
        reset_cycle(1'b0, 1'b0, 16'h0000);

        // ID and reset values of the register map.
        cycle(1'b1, 1'b0, 16'h7F00, 16'h0, '0);
        chk("id", 32'(io_din), 32'hF10C);
        for (int r = 1; r <= 5; r++) cycle(1'b1, 1'b0, 16'h7F00 | 16'(r), 16'h0, '0);

        // Slot read.
        cycle(1'b1, 1'b0, 16'h6304, 16'h0, '0);
        chk("slot3_read", 32'(io_din), 32'hBEEF);

        // Unmapped read.
        cycle(1'b1, 1'b0, 16'h5000, 16'h0, '0);
        chk("unmapped_read", 32'(io_din), 32'h0666);
        cycle(1'b1, 1'b0, 16'h7F03, 16'h0, '0);
        chk("err_addr", 32'(io_din), 32'h5000);
        cycle(1'b1, 1'b0, 16'h7FA4, 16'h0, '0);
        chk("err_cnt", 32'(io_din), 32'h0001);

        // Masked interrupt then W1C.
        cycle(1'b0, 1'b1, 16'h7F02, 16'h0004, '0);
        idle(NS'(4));
        idle('0);
        idle('0);
        chk("irq_set", 32'(irq), 32'h1);
        cycle(1'b1, 1'b0, 16'h7F01, 16'h0, '0);
        chk("pend_set", 32'(io_din), 32'h0004);
        cycle(1'b0, 1'b1, 16'h7F01, 16'h0004, '0);
        idle('0);
        idle('0);
        chk("irq_clr", 32'(irq), 32'h0);

        // New edge coinciding with W1C: set wins.
        idle('0);
        idle(NS'(4));
        cycle(1'b0, 1'b1, 16'h7F01, 16'h0004, NS'(4));
        cycle(1'b1, 1'b0, 16'h7F01, 16'h0, NS'(4));
        chk("set_wins", 32'(io_din), 32'h0004);

        // Overlapped control page on instance b: page 7F is the fabric, not slot 2.
        cycle(1'b1, 1'b0, 16'h7F00, 16'h0, '0);
        chk("overlap_id", 32'(b_din), 32'hF104);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rw = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: a = {8'h60 + 8'($urandom_range(0, NS - 1)), 8'($urandom)};
                1: a = {8'h7F, 8'($urandom)};
                default: a = 16'($urandom);
            endcase
            cycle(rw[1], rw[0], a, 16'($urandom), NS'($urandom));
        end

        // Saturating error counter.
        cycle(1'b0, 1'b1, 16'h7F04, 16'h1234, '0);
        for (int n = 0; n < 65535; n++) begin
            cycle(1'b0, 1'b1, 16'h0012, 16'h0, '0);
        end
        cycle(1'b1, 1'b0, 16'h7F04, 16'h0, '0);
        chk("err_cnt_max", 32'(io_din), 32'hFFFF);
        cycle(1'b1, 1'b0, 16'h8001, 16'h0, '0);
        cycle(1'b1, 1'b0, 16'h7F04, 16'h0, '0);
        chk("err_cnt_sat", 32'(io_din), 32'hFFFF);
        cycle(1'b0, 1'b1, 16'h7F04, 16'h0000, '0);
        cycle(1'b1, 1'b0, 16'h7F04, 16'h0, '0);
        chk("err_cnt_clr", 32'(io_din), 32'h0000);

        // Reset during a read discards it and restores reset state.
        cycle(1'b0, 1'b1, 16'h7F02, 16'hFFFF, '0);
        idle(NS'(3));
        idle('0);
        cycle(1'b1, 1'b0, 16'h4321, 16'h0, '0);
        cycle(1'b1, 1'b0, 16'h7F00, 16'h0, '0);
        chk("id_before_rst", 32'(io_din), 32'hF10C);
        reset_cycle(1'b1, 1'b1, 16'h7F02);
        for (int r = 1; r <= 4; r++) begin
            cycle(1'b1, 1'b0, 16'h7F00 | 16'(r), 16'h0, '0);
            chk("post_rst_reg", 32'(io_din), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/j1_io_fabric.md
J1_IO_FABRIC -- requirements
Module: j1_io_fabric

Interface
REQ-001 SHALL have parameter N_SLOTS, default 8, number of peripheral slots (legal 1..16).
REQ-002 SHALL have parameter BASE_PAGE, default 8'h60, io_addr[15:8] page of slot 0; slot i occupies page BASE_PAGE+i.
REQ-003 SHALL have parameter CTRL_PAGE, default 8'h7F, io_addr[15:8] page of the fabric's own registers.
REQ-004 SHALL have parameter DEFAULT_RDATA, default 16'h0666, read data for unmapped addresses.
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports named as follows.
REQ-006 sys_clk_i  input  1  system clock; all state updates on its rising edge.
REQ-007 sys_rst_i  input  1  synchronous active-high reset.
REQ-008 io_rd / io_wr  input  1 each  J1 read / write strobes.
REQ-009 io_addr  input  16  J1 I/O address.
REQ-010 io_dout  input  16  J1 write data.
REQ-011 io_din  output  16  registered read data to J1.
REQ-012 per_cs  output  N_SLOTS  one-hot slot chip select.
REQ-013 per_rd / per_wr  output  1 each  copies of io_rd / io_wr.
REQ-014 per_addr  output  8  io_addr[7:0]; per_wdata  output  16  io_dout.
REQ-015 per_rdata  input  16*N_SLOTS  slot read data, slot i at bits [16i+15:16i].
REQ-016 per_irq  input  N_SLOTS  level interrupt requests from slots.
REQ-017 irq  output  1  aggregated masked interrupt to CPU.

Function
REQ-018 per_cs[i] SHALL be combinationally 1 only when (io_rd|io_wr)=1 and io_addr[15:8]==BASE_PAGE+i; all other bits 0.
REQ-019 If CTRL_PAGE falls inside the slot range, the control page SHALL win and that slot's per_cs SHALL never assert.
REQ-020 An access is unmapped when (io_rd|io_wr)=1 and the page is neither a slot page nor CTRL_PAGE.
REQ-021 io_din SHALL update one cycle after a cycle with io_rd=1: selected slot's per_rdata, control register value, or DEFAULT_RDATA if unmapped; it SHALL hold its value when io_rd=0.
REQ-022 io_rd and io_wr both high SHALL perform the write and also return read data per REQ-021.
REQ-023 Control registers are selected by io_addr[3:0] within CTRL_PAGE; io_addr[7:4] is ignored.
REQ-024 0x0 ID (RO) = {8'hF1, N_SLOTS[7:0]}.
REQ-025 0x1 IRQ_PEND (R/W1C), bits [N_SLOTS-1:0] valid, upper bits read 0.
REQ-026 0x2 IRQ_MASK (RW), bits above N_SLOTS-1 read 0 and ignore writes.
REQ-027 0x3 ERR_ADDR (RO) = io_addr of the most recent unmapped access.
REQ-028 0x4 ERR_CNT (RO), write of any value clears to 0.
REQ-029 Addresses 0x5..0xF SHALL read 16'h0000 and ignore writes.
REQ-030 per_irq SHALL be registered once; a 0->1 transition of the registered value SHALL set IRQ_PEND[i] on the next edge.
REQ-031 A new edge and a W1C on the same bit in the same cycle SHALL leave the bit set (set wins).
REQ-032 irq SHALL be registered: irq = |(IRQ_PEND & IRQ_MASK), one cycle after the pending/mask change.
REQ-033 Each unmapped access cycle SHALL capture ERR_ADDR and increment ERR_CNT, saturating at 16'hFFFF.
REQ-034 An unmapped access and an ERR_CNT clear in the same cycle are impossible (distinct pages); ERR_CNT write SHALL take priority by construction.
REQ-035 A multi-cycle strobe SHALL count once per cycle the strobe is high.

Reset
REQ-036 On sys_rst_i=1 at a clock edge: io_din=16'h0000, irq=0, IRQ_PEND=0, IRQ_MASK=0, ERR_ADDR=0, ERR_CNT=0, irq edge-detect register=0.
REQ-037 Reset asserted mid-access SHALL discard the access: no register write, no ERR update, io_din=0 the following cycle.
REQ-038 per_cs/per_rd/per_wr/per_addr/per_wdata SHALL remain combinational passthroughs during reset.

Verification
REQ-039 Read at 16'h6304 with per_rdata slot 3 = 16'hBEEF -> per_cs=8'b00001000 during strobe; io_din=16'hBEEF next cycle.
REQ-040 Read at 16'h5000 -> no per_cs; io_din=16'h0666; ERR_ADDR=16'h5000; ERR_CNT=1.
REQ-041 Write IRQ_MASK(16'h7F02)=16'h0004, pulse per_irq[2] -> IRQ_PEND=16'h0004 and irq=1; write 16'h0004 to 16'h7F01 -> irq=0.
REQ-042 per_irq[2] rising edge in the same cycle as W1C of bit 2 -> IRQ_PEND[2] remains 1.
REQ-043 Force ERR_CNT to 16'hFFFF via 65535 unmapped accesses, one more -> stays 16'hFFFF; write to 16'h7F04 -> 0.
REQ-044 Read 16'h7F00 with N_SLOTS=12 -> io_din=16'hF10C; assert sys_rst_i mid-read -> io_din=0, all registers at reset values.
